// File: rtl/sc_regbank_seqctrl.sv
// Register-bank transfer sequencer.
// Accepts one register-transfer request at a time, then drives one-hot read-bus
// enables, an ALU start pulse and a one-hot write strobe in a fixed cycle order
// so that no two registers ever drive the same bus.
module sc_regbank_seqctrl #(
  parameter int NREGS   = 8,
  parameter int SELW    = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             SC_RegBANKCTRL_CLOCK_50,
  input  logic             SC_RegBANKCTRL_RESET_InLow,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic [SELW-1:0]  Req_SelA,
  input  logic [SELW-1:0]  Req_SelB,
  input  logic [SELW-1:0]  Req_SelDest,
  input  logic [1:0]       Req_Mode,
  output logic [NREGS-1:0] EnableBus_A,
  output logic [NREGS-1:0] EnableBus_B,
  output logic [NREGS-1:0] Write_Strobe,
  output logic             ALU_Start,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [1:0] M_ALU  = 2'b00;
  localparam logic [1:0] M_MOVE = 2'b01;
  localparam logic [1:0] M_READ = 2'b10;
  localparam logic [1:0] M_RSV  = 2'b11;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_a_q, sel_a_d;
  logic [SELW-1:0] sel_b_q, sel_b_d;
  logic [SELW-1:0] sel_dest_q, sel_dest_d;
  logic [1:0]      mode_q, mode_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            req_bad;

  // True when a register index does not name a register in the bank.
  function automatic logic idx_bad(input logic [SELW-1:0] s);
    return 32'(s) >= 32'(NREGS);
  endfunction

  // One-hot decode of a (known valid) register index.
  function automatic logic [NREGS-1:0] onehot(input logic [SELW-1:0] s);
    logic [NREGS-1:0] v;
    v    = '0;
    v[0] = 1'b1;
    return v << s;
  endfunction

  // Request legality: SelB only matters for ALU, SelDest only for ALU/MOVE.
  always_comb begin
    req_bad = 1'b0;
    if (Req_Mode == M_RSV)                              req_bad = 1'b1;
    if (idx_bad(Req_SelA))                              req_bad = 1'b1;
    if ((Req_Mode == M_ALU) && idx_bad(Req_SelB))       req_bad = 1'b1;
    if ((Req_Mode != M_READ) && idx_bad(Req_SelDest))   req_bad = 1'b1;
  end

  // State, latched request fields and EXEC counter; reset clears everything.
  always_ff @(posedge SC_RegBANKCTRL_CLOCK_50 or negedge SC_RegBANKCTRL_RESET_InLow) begin
    if (!SC_RegBANKCTRL_RESET_InLow) begin
      state_q    <= S_IDLE;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      sel_dest_q <= '0;
      mode_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      sel_dest_q <= sel_dest_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic: fields latch only on acceptance in IDLE.
  always_comb begin
    state_d    = state_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    sel_dest_d = sel_dest_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Req_Valid) begin
          sel_a_d    = Req_SelA;
          sel_b_d    = Req_SelB;
          sel_dest_d = Req_SelDest;
          mode_d     = Req_Mode;
          state_d    = req_bad ? S_ERR : S_READ;
        end
      end
      S_READ: begin
        if ((mode_q == M_ALU) && (ALU_LAT > 0)) begin
          state_d = S_EXEC;
          cnt_d   = 4'(ALU_LAT - 1);
        end else if (mode_q == M_READ) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) state_d = S_WRITE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset drops them without waiting for a clock.
  always_comb begin
    EnableBus_A  = '0;
    EnableBus_B  = '0;
    Write_Strobe = '0;
    ALU_Start    = 1'b0;
    Done         = 1'b0;
    Error        = 1'b0;
    Busy         = (state_q != S_IDLE);
    Req_Ready    = (state_q == S_IDLE);
    case (state_q)
      S_READ, S_EXEC, S_WRITE: begin
        EnableBus_A = onehot(sel_a_q);
        if (mode_q == M_ALU) EnableBus_B = onehot(sel_b_q);
        if (state_q == S_READ)  ALU_Start    = 1'b1;
        if (state_q == S_WRITE) Write_Strobe = onehot(sel_dest_q);
      end
      S_DONE:  Done  = 1'b1;
      S_ERR:   Error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sc_regbank_seqctrl.sv
module tb_sc_regbank_seqctrl;

  localparam int NI = 4;

  typedef struct packed {
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ws;
    logic       st;
    logic       dn;
    logic       er;
    logic       bz;
    logic       rd;
  } cyc_t;

  logic       clk;
  logic       rst_n;
  logic       vld [NI];
  logic [3:0] sa  [NI];
  logic [3:0] sb  [NI];
  logic [3:0] sd  [NI];
  logic [1:0] md  [NI];
  logic       rdy [NI];
  logic [7:0] ea  [NI];
  logic [7:0] eb  [NI];
  logic [7:0] ws  [NI];
  logic       st  [NI];
  logic       bz  [NI];
  logic       dn  [NI];
  logic       er  [NI];

  int   errors;
  int   checks;
  cyc_t exp_q[$];
  bit   ws2_armed;
  bit   ws2_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 4 : 7;
    sc_regbank_seqctrl #(.NREGS(8), .SELW(4), .ALU_LAT(L)) u_dut (
      .SC_RegBANKCTRL_CLOCK_50   (clk),
      .SC_RegBANKCTRL_RESET_InLow(rst_n),
      .Req_Valid                 (vld[g]),
      .Req_Ready                 (rdy[g]),
      .Req_SelA                  (sa[g]),
      .Req_SelB                  (sb[g]),
      .Req_SelDest               (sd[g]),
      .Req_Mode                  (md[g]),
      .EnableBus_A               (ea[g]),
      .EnableBus_B               (eb[g]),
      .Write_Strobe              (ws[g]),
      .ALU_Start                 (st[g]),
      .Busy                      (bz[g]),
      .Done                      (dn[g]),
      .Error                     (er[g])
    );
  end

  function automatic int lat_of(input int i);
    case (i)
      0: return 0;
      1: return 1;
      2: return 4;
      default: return 7;
    endcase
  endfunction

  function automatic cyc_t observe(input int i);
    cyc_t o;
    o = '{ea: ea[i], eb: eb[i], ws: ws[i], st: st[i], dn: dn[i], er: er[i], bz: bz[i], rd: rdy[i]};
    return o;
  endfunction

  function automatic cyc_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] w,
                              input logic s, input logic d, input logic e);
    cyc_t c;
    c = '{ea: a, eb: b, ws: w, st: s, dn: d, er: e, bz: 1'b1, rd: 1'b0};
    return c;
  endfunction

  // Expected cycle-by-cycle outputs of one accepted request, derived from the request alone.
  task automatic push_expect(input int lat, input logic [1:0] m, input logic [3:0] a,
                             input logic [3:0] b, input logic [3:0] d);
    bit         bad;
    logic [7:0] oa, ob, od;
    bad = (m == 2'b11) || (a >= 8) || ((m == 2'b00) && (b >= 8)) || ((m != 2'b10) && (d >= 8));
    if (bad) begin
      exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
      return;
    end
    oa = 8'h01 << a;
    ob = (m == 2'b00) ? (8'h01 << b) : 8'h00;
    od = 8'h01 << d;
    exp_q.push_back(mk(oa, ob, 8'h00, 1'b1, 1'b0, 1'b0));
    if (m == 2'b00)
      for (int k = 0; k < lat; k++) exp_q.push_back(mk(oa, ob, 8'h00, 1'b0, 1'b0, 1'b0));
    if (m != 2'b10) exp_q.push_back(mk(oa, ob, od, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
  endtask

  // Issue one request on instance i, then compare every cycle against the scoreboard.
  task automatic run_op(input int i, input logic [1:0] m, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] d, input bit hold,
                        output int waits);
    cyc_t e, o;
    int   cyc;
    waits = 0;
    @(negedge clk);
    while (!rdy[i] && waits < 40) begin
      if (hold) begin
        sa[i] = 4'($urandom_range(0, 15));
        sb[i] = 4'($urandom_range(0, 15));
        sd[i] = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      waits++;
    end
    if (!rdy[i]) begin
      checks++; errors++;
      $display("FAIL ready_timeout inst%0d: Req_Ready still 0 after %0d cycles, required 1", i, waits);
      return;
    end
    md[i] = m; sa[i] = a; sb[i] = b; sd[i] = d; vld[i] = 1'b1;
    @(posedge clk);
    push_expect(lat_of(i), m, a, b, d);
    #1;
    if (!hold) vld[i] = 1'b0;
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe(i);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL trace inst%0d mode=%b a=%0d b=%0d d=%0d cycle%0d: got ea=%h eb=%h ws=%h st=%b dn=%b er=%b bz=%b rd=%b, required ea=%h eb=%h ws=%h st=%b dn=%b er=%b bz=%b rd=%b",
                 i, m, a, b, d, cyc, o.ea, o.eb, o.ws, o.st, o.dn, o.er, o.bz, o.rd,
                 e.ea, e.eb, e.ws, e.st, e.dn, e.er, e.bz, e.rd);
      end
      if (exp_q.size() > 0) begin
        if (hold) begin
          @(negedge clk);
          sa[i] = 4'($urandom_range(0, 15));
          sb[i] = 4'($urandom_range(0, 15));
          sd[i] = 4'($urandom_range(0, 15));
          md[i] = 2'($urandom_range(0, 3));
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
  endtask

  // Per-cycle bus-safety invariants on every instance.
  task automatic inv_monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ($countones(ea[i]) > 1 || $countones(eb[i]) > 1 || $countones(ws[i]) > 1 ||
            (dn[i] && er[i]) || ((ws[i] != 8'h00) && (!bz[i] || dn[i] || er[i] || st[i]))) begin
          errors++;
          $display("FAIL invariant inst%0d: ea=%h eb=%h ws=%h st=%b dn=%b er=%b bz=%b", i,
                   ea[i], eb[i], ws[i], st[i], dn[i], er[i], bz[i]);
        end
        if (i == 2 && ws2_armed && ws[2] != 8'h00) ws2_seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    cyc_t idle;
    idle = '{ea: 8'h00, eb: 8'h00, ws: 8'h00, st: 1'b0, dn: 1'b0, er: 1'b0, bz: 1'b0, rd: 1'b1};
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (observe(i) !== idle) begin
        errors++;
        $display("FAIL reset_state inst%0d: got %h, required %h", i, observe(i), idle);
      end
    end
  endtask

  task automatic test_alu();
    int w;
    run_op(1, 2'b00, 4'd2, 4'd5, 4'd7, 1'b0, w);
    run_op(1, 2'b00, 4'd3, 4'd3, 4'd0, 1'b0, w);
    run_op(0, 2'b00, 4'd6, 4'd1, 4'd4, 1'b0, w);
    run_op(3, 2'b00, 4'd0, 4'd7, 4'd0, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    run_op(1, 2'b01, 4'd1, 4'd0, 4'd1, 1'b0, w);
    run_op(1, 2'b01, 4'd4, 4'd0, 4'd0, 1'b0, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL back_to_back_accept: waited %0d cycles after Done, required 1", w);
    end
  endtask

  task automatic test_read_and_errors();
    int w;
    run_op(1, 2'b10, 4'd3, 4'd0, 4'd0, 1'b0, w);
    run_op(1, 2'b10, 4'd5, 4'd15, 4'd9, 1'b0, w);
    run_op(1, 2'b11, 4'd3, 4'd1, 4'd2, 1'b0, w);
    run_op(1, 2'b00, 4'd1, 4'd2, 4'd9, 1'b0, w);
    run_op(1, 2'b01, 4'd1, 4'd2, 4'd9, 1'b0, w);
    run_op(1, 2'b00, 4'd1, 4'd12, 4'd2, 1'b0, w);
    run_op(1, 2'b01, 4'd8, 4'd0, 4'd2, 1'b0, w);
    run_op(1, 2'b01, 4'd7, 4'd15, 4'd6, 1'b0, w);
  endtask

  task automatic test_hold_valid();
    int w;
    run_op(1, 2'b00, 4'd4, 4'd6, 4'd2, 1'b1, w);
    run_op(1, 2'b01, 4'd5, 4'd0, 4'd3, 1'b1, w);
    run_op(3, 2'b00, 4'd1, 4'd2, 4'd3, 1'b1, w);
    vld[1] = 1'b0;
    vld[3] = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    int w;
    ws2_seen  = 1'b0;
    ws2_armed = 1'b1;
    @(negedge clk);
    md[2] = 2'b00; sa[2] = 4'd1; sb[2] = 4'd2; sd[2] = 4'd6; vld[2] = 1'b1;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ea[2] !== 8'h02 || eb[2] !== 8'h04 || bz[2] !== 1'b1) begin
      errors++;
      $display("FAIL exec_before_reset: ea=%h eb=%h bz=%b, required ea=02 eb=04 bz=1", ea[2], eb[2], bz[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ea[2] !== 8'h00 || eb[2] !== 8'h00 || ws[2] !== 8'h00 || bz[2] !== 1'b0 ||
        rdy[2] !== 1'b1 || st[2] !== 1'b0 || dn[2] !== 1'b0 || er[2] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ea=%h eb=%h ws=%h bz=%b rdy=%b, required all 0 with rdy=1",
               ea[2], eb[2], ws[2], bz[2], rdy[2]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    ws2_armed = 1'b0;
    checks++;
    if (ws2_seen !== 1'b0 || bz[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_write: write seen=%b busy=%b, required 0 and 0", ws2_seen, bz[2]);
    end
    run_op(2, 2'b00, 4'd1, 4'd2, 4'd6, 1'b0, w);
  endtask

  task automatic test_random();
    int w, r, i;
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 2);
      i = (r == 2) ? 3 : r;
      run_op(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'b0, w);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    ws2_armed = 1'b0;
    ws2_seen  = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0; sa[i] = '0; sb[i] = '0; sd[i] = '0; md[i] = '0;
    end
    #1;
    test_reset();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    fork
      inv_monitor();
    join_none
    test_alu();
    test_back_to_back();
    test_read_and_errors();
    test_hold_valid();
    test_reset_mid_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_regbank_seqctrl.md
Name: sc_regbank_seqctrl

Overview:
Sequencer for a bank of NREGS general registers sharing two tri-state read buses (A, B) and one write data bus. It accepts one register-transfer request at a time over a valid/ready handshake. It then drives one-hot bus-A/bus-B output enables and a one-hot write strobe in a fixed cycle order, so no two registers ever drive the same bus. It sits between the instruction decoder and the register bank/ALU in the datapath.

Parameters:
NREGS, 8, number of registers in the bank; width of the enable/write vectors
SELW, 3, width of register index fields; 2^SELW >= NREGS
ALU_LAT, 1, cycles spent in EXEC waiting for the ALU result (0..15)

Ports:
SC_RegBANKCTRL_CLOCK_50  in  1  system clock; all controller state updates on rising edge
SC_RegBANKCTRL_RESET_InLow  in  1  asynchronous, active-low reset
Req_Valid  in  1  request present
Req_Ready  out  1  controller can accept a request
Req_SelA  in  SELW  source register for bus A
Req_SelB  in  SELW  source register for bus B
Req_SelDest  in  SELW  destination register
Req_Mode  in  2  00 ALU (A,B->Dest), 01 MOVE (A->Dest), 10 READ (A only, no write), 11 reserved
EnableBus_A  out  NREGS  one-hot (or zero) output enable to bus A
EnableBus_B  out  NREGS  one-hot (or zero) output enable to bus B
Write_Strobe  out  NREGS  one-hot (or zero) write enable, per-register write input
ALU_Start  out  1  one-cycle pulse, operands valid on buses
Busy  out  1  high in any state other than IDLE
Done  out  1  one-cycle completion pulse
Error  out  1  one-cycle pulse, request rejected

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; latched fields = 0; EXEC counter = 0.
  - All outputs 0 except Req_Ready = 1.
  - Reset mid-operation drops all enables and strobes immediately; no partial write occurs.
- Interface clocking: one clock domain. The register bank captures on the falling edge, so a Write_Strobe held high for a full rising-to-rising cycle is captured exactly once, mid-cycle.
- States: IDLE, READ, EXEC, WRITE, DONE, ERR.
- IDLE:
  - Req_Ready = 1. A request is accepted when Req_Valid & Req_Ready are both high at a rising edge.
  - On acceptance, SelA, SelB, SelDest and Mode are latched. Inputs are ignored after acceptance.
  - Go to ERR if Mode = 11 or any used index >= NREGS (SelB is checked only in ALU mode; SelDest only in ALU/MOVE). Otherwise go to READ.
- READ (1 cycle):
  - EnableBus_A[SelA] = 1. EnableBus_B[SelB] = 1 in ALU mode only. ALU_Start = 1.
  - Next state: EXEC if ALU_LAT > 0 and Mode = ALU; WRITE if MOVE, or ALU with ALU_LAT = 0; DONE if READ mode.
- EXEC:
  - Bus enables held. A 4-bit counter loads ALU_LAT-1 on entry and decrements each cycle.
  - Go to WRITE when the counter = 0, so EXEC lasts exactly ALU_LAT cycles.
- WRITE (1 cycle): bus enables held; Write_Strobe[SelDest] = 1; next state DONE.
- DONE (1 cycle): all enables 0; Done = 1; next state IDLE.
- ERR (1 cycle): all enables 0; Error = 1; next state IDLE. No register is touched.
- Busy = (state != IDLE). Req_Ready = (state == IDLE). Req_Valid while Busy is ignored and not queued.
- Latency from acceptance edge to Done high: ALU = ALU_LAT + 3 cycles; MOVE = 3; READ = 2; error = 1 (Error high).
- Back-to-back: a new request can be accepted in the cycle after DONE, when IDLE is re-entered.
- SelA == SelB is legal: the same register drives both buses.
- SelDest == SelA is legal: the bus still shows the old value during WRITE, and the new value is visible from the following cycle.
- Invariants, checked by bench assertions every cycle:
  - popcount(EnableBus_A) <= 1, popcount(EnableBus_B) <= 1, popcount(Write_Strobe) <= 1.
  - Write_Strobe is nonzero only in WRITE.
  - Done and Error are never high together.

Test Plan:
- ALU, ALU_LAT=1: accept SelA=2, SelB=5, Dest=7 -> EnableBus_A=8'h04 and EnableBus_B=8'h20 for 3 cycles; ALU_Start in READ only; Write_Strobe=8'h80 in cycle 3; Done in cycle 4.
- MOVE SelA=1 -> Dest=1 -> EnableBus_A=8'h02 for 2 cycles, EnableBus_B=0, Write_Strobe=8'h02 in cycle 2, Done in cycle 3; next request is accepted in the cycle after Done.
- READ mode SelA=3, plus Mode=11, plus SelDest=9 with NREGS=8, SELW=4 -> READ: no Write_Strobe, Done after 2 cycles; both invalid requests: single Error pulse, all vectors 0.
- Req_Valid held high through a whole ALU op with changing Sel inputs -> Req_Ready=0 while Busy; latched indices unchanged; exactly one accept per IDLE visit.
- Reset asserted during EXEC (ALU_LAT=4) -> all vectors 0 and Busy=0 asynchronously, Req_Ready=1; target register is not written; a fresh op after release completes normally.
- Random 2000-op sequence, ALU_LAT in {0,1,7} -> one-hot/zero invariants never violated; each op's Done latency matches the formula.
